ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Shares the open-drain PS/2 clock/data lines with the existing keyboard receiver.
- Flags ownership of the bus via tx_busy so the receiver can ignore clock edges generated during a transmit.
- Reports completion or failure with single-cycle pulses.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 37 +++
 rtl/ps2_host_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side constants, state encoding and parity helper.
// Pure definitions: no latency, no flow control.
package ps2_pkg;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_CODE    = 8'hFA;

    localparam logic [1:0] ERR_RTS  = 2'd1;
    localparam logic [1:0] ERR_BIT  = 2'd2;
    localparam logic [1:0] ERR_NACK = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser/debounce for one PS/2 line plus falling-edge strobe; output lags the pad by
// FILTER_LEN+1 cycles, no backpressure.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_o,
    output logic fe_o
);

    logic [FILTER_LEN-1:0] sh_q;
    logic                  filt_q;
    logic                  prev_q;

    // Filtered level only moves once the whole window agrees.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sh_q   <= '1;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sh_q   <= {sh_q[FILTER_LEN-2:0], line_i};
            prev_q <= filt_q;
            if (&sh_q) begin
                filt_q <= 1'b1;
            end else if (~|sh_q) begin
                filt_q <= 1'b0;
            end
        end
    end

    assign line_o = filt_q;
    assign fe_o   = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter; PS2_TX_RETRY_EN adds one silent retry per byte.
// Line activity starts the cycle after accept; tx_ready low while busy, extra tx_valid ignored.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = 10000,
    parameter int RTS_TIMEOUT_CYCLES = 1500000,
    parameter int BIT_TIMEOUT_CYCLES = 200000,
    parameter int FILTER_LEN         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);

    localparam int CNT_MAX0 = (RTS_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ? RTS_TIMEOUT_CYCLES
                                                                       : BIT_TIMEOUT_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > INHIBIT_CYCLES) ? CNT_MAX0 : INHIBIT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       data_q;
    logic             par_q;
    logic [3:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             ready_q;
    logic             done_q;
    logic             error_q;
    logic [1:0]       err_code_q;
`ifdef PS2_TX_RETRY_EN
    logic             retry_q;
`endif

    logic clk_filt;
    logic clk_fe;
    logic data_filt;
    logic data_fe_unused;
    logic accept;
    logic fail;
    logic [1:0] fail_code;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .line_i  (ps2_clk_in),
        .line_o  (clk_filt),
        .fe_o    (clk_fe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .line_i  (ps2_data_in),
        .line_o  (data_filt),
        .fe_o    (data_fe_unused)
    );

    assign accept = tx_valid & ready_q & (state_q == IDLE);

    // A device edge in the same cycle as an expiring count always wins.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_RTS;
        case (state_q)
            RTS: begin
                if (!clk_fe && cnt_q == RTS_LAST) begin
                    fail = 1'b1;
                end
            end
            DATA, PARITY, STOP: begin
                if (!clk_fe && cnt_q == BIT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT;
                end
            end
            ACK: begin
                if (data_filt) begin
                    fail      = 1'b1;
                    fail_code = ERR_NACK;
                end else if (!clk_fe && cnt_q == BIT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT;
                end
            end
            WAIT_IDLE: begin
                if (!(clk_filt && data_filt) && !clk_fe && cnt_q == BIT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= (state_q == IDLE) && !accept;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        data_q    <= tx_data;
                        par_q     <= odd_parity(tx_data);
                        idx_q     <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retry_q   <= 1'b0;
`endif
                    end
                end
                INHIBIT: begin
                    // Start bit goes low during the final inhibit cycle.
                    if (cnt_q == INH_LAST) begin
                        clk_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RTS;
                    end else if (cnt_q == INH_PRE) begin
                        data_oe_q <= 1'b1;
                    end
                end
                RTS: begin
                    if (clk_fe) begin
                        data_oe_q <= ~data_q[0];
                        idx_q     <= 4'd1;
                        cnt_q     <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (clk_fe) begin
                        cnt_q <= '0;
                        if (idx_q == 4'd8) begin
                            data_oe_q <= ~par_q;
                            state_q   <= PARITY;
                        end else begin
                            data_oe_q <= ~data_q[idx_q[2:0]];
                            idx_q     <= idx_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (clk_fe) begin
                        cnt_q     <= '0;
                        data_oe_q <= 1'b0;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (clk_fe) begin
                        cnt_q   <= '0;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (clk_fe) begin
                        cnt_q <= '0;
                    end
                    if (!data_filt) begin
                        state_q <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_fe) begin
                        cnt_q <= '0;
                    end
                    if (clk_filt && data_filt) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (fail) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                cnt_q     <= '0;
`ifdef PS2_TX_RETRY_EN
                if (!retry_q) begin
                    retry_q  <= 1'b1;
                    clk_oe_q <= 1'b1;
                    idx_q    <= '0;
                    state_q  <= INHIBIT;
                end else begin
                    error_q    <= 1'b1;
                    err_code_q <= fail_code;
                    state_q    <= IDLE;
                end
`else
                error_q    <= 1'b1;
                err_code_q <= fail_code;
                state_q    <= IDLE;
`endif
            end
        end
    end

    assign tx_ready    = ready_q;
    assign tx_busy     = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard that clocks frames,
// samples bits on rising clock and optionally acks; outcomes checked against frame rules.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 16;
    localparam int RTS_T = 400;
    localparam int BIT_T = 300;
    localparam int FL    = 4;
    localparam int HALF  = 12;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (INH),
        .RTS_TIMEOUT_CYCLES (RTS_T),
        .BIT_TIMEOUT_CYCLES (BIT_T),
        .FILTER_LEN         (FL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          inh_cnt = 0;
    int          run_len = 0;
    int          run_st = 0;
    int          last_inh_len = 0;
    int          last_start_len = 0;
    logic [1:0]  last_code = 2'd0;
    logic        oe_at_err = 1'b0;
    logic        prev_oe = 1'b0;
    logic [10:0] seen = '0;
    logic [1:0]  exp_code = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counters and inhibit-window measurements, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            last_code = err_code;
            oe_at_err = ps2_clk_oe | ps2_data_oe;
        end
        if (ps2_clk_oe && !prev_oe) inh_cnt++;
        prev_oe = ps2_clk_oe;
        if (ps2_clk_oe) begin
            run_len++;
            if (ps2_data_oe) run_st++;
        end else if (run_len != 0) begin
            last_inh_len   = run_len;
            last_start_len = run_st;
            run_len = 0;
            run_st  = 0;
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", n < 200, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = $urandom;
        check("first_activity_clk_oe", ps2_clk_oe, 1);
    endtask

    task automatic device(input int nclk, input bit ack);
        int n;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < RTS_T + 200) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_seen", n < RTS_T + 200, 1);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < INH + 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("inhibit_len", last_inh_len, INH);
        check("start_in_last_inhibit_cycle", last_start_len, 1);
        check("rts_data_held_low", ps2_data_oe, 1);
        if (nclk == 0) return;
        repeat ($urandom_range(10, 40)) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (3) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            seen[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
            else repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic check_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            check("data_bit", seen[i], b[i]);
            if (b[i]) ones++;
        end
        check("parity_bit", seen[8], (ones % 2 == 0) ? 1 : 0);
        check("stop_bit", seen[9], 1);
    endtask

    task automatic settle(input int d0, input int e0, input int exp_done, input int exp_err);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < RTS_T + BIT_T + 100) begin
            @(negedge clk);
            n++;
        end
        check("outcome_in_time", n < RTS_T + BIT_T + 100, 1);
        repeat (6) @(negedge clk);
        check("done_pulses", done_cnt - d0, exp_done);
        check("error_pulses", err_cnt - e0, exp_err);
        check("ready_after_outcome", tx_ready, 1);
        check("busy_after_outcome", tx_busy, 0);
        check("err_code_value", err_code, exp_code);
    endtask

    task automatic good_xact(input logic [7:0] b);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        device(11, 1'b1);
        check_frame(b);
        check("ack_driven_low", seen[10], 0);
        settle(d0, e0, 1, 0);
    endtask

    initial begin
        int d0, e0, c;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", tx_ready, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_err_code", err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", tx_ready, 1);

        good_xact(CMD_SET_LED);
        good_xact(8'h00);
        for (int k = 0; k < 4; k++) good_xact(8'($urandom));

        // NACK: device leaves data high on the 11th falling edge.
        b = 8'($urandom);
        d0 = done_cnt; e0 = err_cnt;
        send(b);
        for (int a = 0; a < ATTEMPTS; a++) begin
            device(11, 1'b0);
            check_frame(b);
        end
        exp_code = ERR_NACK;
        settle(d0, e0, 0, 1);
        check("nack_code_at_pulse", last_code, ERR_NACK);
        check("nack_lines_released", oe_at_err, 0);

        good_xact(CMD_RESET);

        // Device never answers the request-to-send.
        d0 = done_cnt; e0 = err_cnt;
        send(8'($urandom));
        for (int a = 0; a < ATTEMPTS; a++) device(0, 1'b0);
        c = 0;
        while (tx_error !== 1'b1 && c < RTS_T + 50) begin
            @(negedge clk);
            c++;
        end
        check("rts_timeout_cycles", c, RTS_T);
        exp_code = ERR_RTS;
        settle(d0, e0, 0, 1);
        check("rts_lines_released", oe_at_err, 0);

        // Device stops clocking after four bits.
        d0 = done_cnt; e0 = err_cnt;
        send(8'($urandom));
        for (int a = 0; a < ATTEMPTS; a++) device(4, 1'b0);
        exp_code = ERR_BIT;
        settle(d0, e0, 0, 1);
        check("bit_code_at_pulse", last_code, ERR_BIT);
        good_xact(CMD_ENABLE);

`ifdef PS2_TX_RETRY_EN
        b = 8'($urandom);
        d0 = done_cnt; e0 = err_cnt;
        c = inh_cnt;
        send(b);
        device(11, 1'b0);
        device(11, 1'b1);
        check_frame(b);
        settle(d0, e0, 1, 0);
        check("retry_inhibits", inh_cnt - c, 2);
`endif

        // Reset in the middle of the data phase.
        send(8'h00);
        device(3, 1'b0);
        check("pre_reset_data_oe", ps2_data_oe, 1);
        check("pre_reset_busy", tx_busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_ready", tx_ready, 0);
        check("midrst_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_after_release", tx_ready, 1);
        exp_code = 2'd0;
        check("midrst_err_code", err_code, exp_code);

        good_xact(8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
